traffic_timer: RTL and testbench

TRAFFIC_TIMER -- requirements
Module: traffic_timer

---
 rtl/traffic_timer.sv | 157 +++++++++++++++
 tb/tb_traffic_timer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_timer.sv
// traffic_timer: programmable interval timer for a traffic-light sequencer.
//
// Three 4-bit duration registers (tBASE, tEXT, tYEL) are programmed through a
// synchronized strobe. A start request loads a 5-bit Remaining count with the
// selected duration. The block counts it down in unit ticks and then emits a
// single-cycle expired pulse.
//
// Optional feature macro: TRAFFIC_TIMER_PRESCALE_EN
//   defined   : a prescaler divides clk by DIV_COUNT to form the unit tick
//   undefined : every clk cycle is a unit tick and DIV_COUNT is ignored
//
// Ports:
//   clk            in   system clock, rising edge
//   Reset_n        in   synchronous active-low reset
//   start_timer    in   start / restart request
//   interval [2:0] in   duration select (0 tBASE, 1 tEXT, 2 tYEL, 3 2*tBASE, else tBASE)
//   Prog_Sync      in   program strobe
//   Time_Param_Sel [1:0] in  program target (0 tBASE, 1 tEXT, 2 tYEL, 3 none)
//   Time_Value [3:0] in  program value in seconds (0 restores the default)
//   expired        out  one-cycle pulse at the end of the interval
//   Busy           out  high while counting
//
// state  | meaning
// IDLE   | waiting for start_timer
// COUNT  | Remaining counting down in unit ticks
// EXPIRE | one-cycle expired pulse, then back to IDLE
module traffic_timer #(
  parameter int DIV_COUNT = 100000000
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       start_timer,
  input  logic [2:0] interval,
  input  logic       Prog_Sync,
  input  logic [1:0] Time_Param_Sel,
  input  logic [3:0] Time_Value,
  output logic       expired,
  output logic       Busy
);

  localparam logic [3:0] TBASE_DEF = 4'd6;
  localparam logic [3:0] TEXT_DEF  = 4'd3;
  localparam logic [3:0] TYEL_DEF  = 4'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    EXPIRE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] remaining_q, remaining_d;
  logic [3:0] tbase_q, text_q, tyel_q;
  logic [4:0] duration;
  logic       unit_tick;

  if (DIV_COUNT < 2) begin : g_div_check
    $error("traffic_timer: DIV_COUNT must be at least 2");
  end

`ifdef TRAFFIC_TIMER_PRESCALE_EN
  localparam int PW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_COUNT - 1);

  logic [PW-1:0] presc_q, presc_d;

  assign unit_tick = (presc_q == PRESC_MAX);

  // The prescaler only runs during COUNT; a start always realigns it to zero
  // so the first unit of a fresh count is a full DIV_COUNT cycles long.
  always_comb begin
    presc_d = '0;
    if (!start_timer && state_q == COUNT && !unit_tick) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign unit_tick = 1'b1;
`endif

  // 2*tBASE is formed by a shift into the 5-bit result, so 15 gives 30.
  always_comb begin
    case (interval)
      3'd1:    duration = {1'b0, text_q};
      3'd2:    duration = {1'b0, tyel_q};
      3'd3:    duration = {tbase_q, 1'b0};
      default: duration = {1'b0, tbase_q};
    endcase
  end

  // Remaining is checked for zero before any decrement, which adds the one
  // extra cycle between the last tick and the expired pulse.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    expired     = 1'b0;
    Busy        = 1'b0;
    case (state_q)
      COUNT:  Busy    = 1'b1;
      EXPIRE: expired = 1'b1;
      default: ;
    endcase
    if (start_timer) begin
      state_d     = COUNT;
      remaining_d = duration;
    end else begin
      case (state_q)
        IDLE: ;
        COUNT: begin
          if (remaining_q == 5'd0) begin
            state_d = EXPIRE;
          end else if (unit_tick) begin
            remaining_d = remaining_q - 5'd1;
          end
        end
        EXPIRE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      remaining_q <= 5'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  // Duration registers; the start path reads the pre-write values because
  // these update on the same edge that samples start_timer.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      tbase_q <= TBASE_DEF;
      text_q  <= TEXT_DEF;
      tyel_q  <= TYEL_DEF;
    end else if (Prog_Sync) begin
      case (Time_Param_Sel)
        2'd0:    tbase_q <= (Time_Value == 4'd0) ? TBASE_DEF : Time_Value;
        2'd1:    text_q  <= (Time_Value == 4'd0) ? TEXT_DEF  : Time_Value;
        2'd2:    tyel_q  <= (Time_Value == 4'd0) ? TYEL_DEF  : Time_Value;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_timer.sv
`timescale 1ns/1ps
module tb_traffic_timer;

`ifdef TRAFFIC_TIMER_PRESCALE_EN
  localparam int U = 4;
`else
  localparam int U = 1;
`endif
  localparam int BUDGET = 40 * U + 10;

  logic       clk;
  logic       Reset_n;
  logic       start_timer;
  logic [2:0] interval;
  logic       Prog_Sync;
  logic [1:0] Time_Param_Sel;
  logic [3:0] Time_Value;
  logic       expired;
  logic       Busy;

  traffic_timer #(.DIV_COUNT(4)) dut (
    .clk            (clk),
    .Reset_n        (Reset_n),
    .start_timer    (start_timer),
    .interval       (interval),
    .Prog_Sync      (Prog_Sync),
    .Time_Param_Sel (Time_Param_Sel),
    .Time_Value     (Time_Value),
    .expired        (expired),
    .Busy           (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  bit mon_en = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: every expired pulse must match the oldest expected time.
  always @(negedge clk) begin
    if (mon_en && expired) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: actual pulse at cycle %0d required none", cyc);
      end else begin
        int t;
        t = exp_q.pop_front();
        if (t != cyc) begin
          n_fail++;
          $display("FAIL pulse_time: actual cycle %0d required cycle %0d", cyc, t);
        end
      end
    end
  end

  // Called just after a negedge; returns the index of the sampling edge.
  task automatic pulse_start(input int intv, output int t0);
    start_timer = 1'b1;
    interval    = intv[2:0];
    @(negedge clk);
    start_timer = 1'b0;
    t0 = cyc;
    check("busy_after_start", int'(Busy), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((Busy || expired) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) check("idle_timeout", 1, 0);
  endtask

  task automatic run(input int intv, input int v);
    int t0;
    pulse_start(intv, t0);
    exp_q.push_back(t0 + v * U + 1);
    wait_idle();
  endtask

  task automatic prog(input int sel, input int val);
    Prog_Sync      = 1'b1;
    Time_Param_Sel = sel[1:0];
    Time_Value     = val[3:0];
    @(negedge clk);
    Prog_Sync = 1'b0;
  endtask

  initial begin
    int t0, t1, n;
    Reset_n = 1'b0; start_timer = 1'b0; interval = '0;
    Prog_Sync = 1'b0; Time_Param_Sel = '0; Time_Value = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(Busy), 0);
    check("reset_expired", int'(expired), 0);
    Reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);

    // default durations through every interval code
    run(2, 2);
    run(3, 12);
    run(1, 3);
    run(0, 6);
    run(6, 6);

    // restart two cycles into a tBASE count: only the restarted pulse appears
    pulse_start(0, t0);
    @(negedge clk);
    pulse_start(0, t1);
    check("restart_edge", t1 - t0, 2);
    exp_q.push_back(t1 + 6 * U + 1);
    wait_idle();

    // restart during the EXPIRE cycle: both pulses expected
    pulse_start(2, t0);
    exp_q.push_back(t0 + 2 * U + 1);
    n = 0;
    while (!expired && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("expire_seen", int'(expired), 1);
    pulse_start(1, t1);
    exp_q.push_back(t1 + 3 * U + 1);
    wait_idle();

    // program and start in the same cycle: old tYEL used, new value next time
    Prog_Sync = 1'b1; Time_Param_Sel = 2'd2; Time_Value = 4'd5;
    pulse_start(2, t0);
    Prog_Sync = 1'b0;
    exp_q.push_back(t0 + 2 * U + 1);
    wait_idle();
    run(2, 5);

    // value 0 restores tYEL default; select 3 writes nothing
    prog(2, 0);
    run(2, 2);
    prog(3, 9);
    run(0, 6);
    run(1, 3);
    run(2, 2);

    // programming mid-count leaves Remaining alone
    pulse_start(1, t0);
    exp_q.push_back(t0 + 3 * U + 1);
    prog(1, 7);
    wait_idle();
    run(1, 7);

    // widest duration: 2*15
    prog(0, 15);
    run(3, 30);
    run(0, 15);

    // reset at cycle 4 of a count aborts it and restores defaults
    pulse_start(0, t0);
    repeat (3) @(negedge clk);
    Reset_n = 1'b0;
    @(negedge clk);
    Reset_n = 1'b1;
    check("abort_busy", int'(Busy), 0);
    check("abort_expired", int'(expired), 0);
    repeat (20 * U) @(negedge clk);
    run(0, 6);
    run(1, 3);
    run(2, 2);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
